demux12_stream: RTL and testbench



---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_fifo.sv | 63 ++++++
 rtl/demux12_stream.sv | 93 +++++++++
 tb/tb_demux12_stream.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and channel-select encodings for the 1-to-2 byte stream demultiplexer.
package demux_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_CNT_W = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a combinational head.
module demux_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_next;
    logic             w_push;
    logic             w_pop;

    // Guard internally so a careless caller cannot corrupt the occupancy.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_next;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/demux12_stream.sv
// Steers a select-tagged byte stream into two independently buffered valid/ready channels,
// each with a wrapping count of accepted beats.
module demux12_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic             S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic             out_valid0,
    output logic             out_valid1,
    input  logic             out_ready0,
    input  logic             out_ready1,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);

    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [WIDTH-1:0] w_head0;
    logic [WIDTH-1:0] w_head1;
    logic             w_accept;
    logic             w_push0;
    logic             w_push1;
    logic             w_pop0;
    logic             w_pop1;
    logic [CNT_W-1:0] r_count0;
    logic [CNT_W-1:0] r_count1;

    // Ready looks only at the selected channel's registered full flag, never at out_ready.
    assign in_ready = ~rst & ~w_full[S];
    assign w_accept = in_valid & in_ready;
    assign w_push0  = w_accept & (S == CH0);
    assign w_push1  = w_accept & (S == CH1);

    assign out_valid0 = ~w_empty[0];
    assign out_valid1 = ~w_empty[1];
    assign w_pop0     = out_valid0 & out_ready0;
    assign w_pop1     = out_valid1 & out_ready1;

    assign Y0 = out_valid0 ? w_head0 : '0;
    assign Y1 = out_valid1 ? w_head1 : '0;

    assign count0 = r_count0;
    assign count1 = r_count1;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push0),
        .i_pop   (w_pop0),
        .i_data  (A),
        .o_full  (w_full[0]),
        .o_empty (w_empty[0]),
        .o_head  (w_head0)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_pop   (w_pop1),
        .i_data  (A),
        .o_full  (w_full[1]),
        .o_empty (w_empty[1]),
        .o_head  (w_head1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count0 <= '0;
            r_count1 <= '0;
        end else begin
            if (w_push0) r_count0 <= r_count0 + CNT_W'(1);
            if (w_push1) r_count1 <= r_count1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux12_stream.sv
// Scoreboard bench for demux12_stream: queue-based reference model, directed scenarios
// followed by randomized traffic.
module tb_demux12_stream;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] A = '0;
    logic             S = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;
    logic             out_valid0;
    logic             out_valid1;
    logic             out_ready0 = 1'b0;
    logic             out_ready1 = 1'b0;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: per-channel contents as queues, plus wrapping beat counts.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [CNT_W-1:0] m_cnt0 = '0;
    logic [CNT_W-1:0] m_cnt1 = '0;
    bit               pop0 = 1'b0;
    bit               pop1 = 1'b0;

    demux12_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .S          (S),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Y0         (Y0),
        .Y1         (Y1),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_ready0 (out_ready0),
        .out_ready1 (out_ready1),
        .count0     (count0),
        .count1     (count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus side: record each accepted beat into the expected queue of its channel.
    always @(posedge clk) begin
        int occ;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_cnt0 <= '0;
            m_cnt1 <= '0;
        end else if (in_valid) begin
            occ = S ? (q1.size() + int'(pop1)) : (q0.size() + int'(pop0));
            if (occ < DEPTH) begin
                if (S) begin
                    q1.push_back(A);
                    m_cnt1 <= m_cnt1 + 1'b1;
                end else begin
                    q0.push_back(A);
                    m_cnt0 <= m_cnt0 + 1'b1;
                end
            end
        end
    end

    // Monitor side: compare DUT outputs at mid-cycle and retire popped beats.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
            chk("rst_y", {16'd0, Y1, Y0}, 32'd0);
            chk("rst_count", {16'd0, count1, count0}, 32'd0);
            pop0 = 1'b0;
            pop1 = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready),
                32'((S ? q1.size() : q0.size()) < DEPTH));
            chk("out_valid0", 32'(out_valid0), 32'(q0.size() != 0));
            chk("out_valid1", 32'(out_valid1), 32'(q1.size() != 0));
            chk("y0", 32'(Y0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
            chk("y1", 32'(Y1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
            chk("count0", 32'(count0), 32'(m_cnt0));
            chk("count1", 32'(count1), 32'(m_cnt1));
            pop0 = out_ready0 && (q0.size() != 0);
            pop1 = out_ready1 && (q1.size() != 0);
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted, bounded.
    task automatic send(input logic [WIDTH-1:0] a, input logic s);
        bit ok = 1'b0;
        A = a;
        S = s;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("send_accepted", 32'(ok), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("async_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
        chk("async_y", {16'd0, Y1, Y0}, 32'd0);
        chk("async_count", {16'd0, count1, count0}, 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        #1;
        chk("first_ready", 32'(in_ready), 32'd1);

        // Reset then route.
        out_ready1 = 1'b0;
        send(8'h81, 1'b1);
        chk("route_y1", 32'(Y1), 32'h81);
        chk("route_count1", 32'(count1), 32'd1);
        chk("route_idle0", {31'd0, out_valid0}, 32'd0);
        out_ready1 = 1'b1;
        step();

        // Backpressure isolation, then full with simultaneous pop.
        out_ready0 = 1'b0;
        send(8'h49, 1'b0);
        send(8'h11, 1'b0);
        A = 8'h98;
        S = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("bp_refused", 32'(in_ready), 32'd0);
        chk("bp_count0", 32'(count0), 32'd2);
        step();
        send(8'h55, 1'b1);
        chk("iso_y1", 32'(Y1), 32'h55);
        out_ready0 = 1'b1;
        A = 8'hA7;
        S = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("full_pop_refused", 32'(in_ready), 32'd0);
        step();
        chk("full_pop_next", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        repeat (4) step();

        // Streaming: 16 alternating beats with both consumers ready.
        do_reset();
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 1'(i % 2));
        chk("stream_count0", 32'(count0), 32'd8);
        chk("stream_count1", 32'(count1), 32'd8);

        // Counter wrap on channel 1.
        do_reset();
        for (int i = 0; i < 256; i++) send(8'(i * 7), 1'b1);
        chk("wrap_count1", 32'(count1), 32'd0);
        repeat (3) step();

        // Mid-stream reset with both channels holding data.
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hD1, 1'b1);
        do_reset();
        repeat (3) step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            S          = 1'($urandom_range(0, 1));
            A          = 8'($urandom);
            out_ready0 = ($urandom_range(0, 9) < 7);
            out_ready1 = ($urandom_range(0, 9) < 7);
            step();
        end

        // Drain, bounded.
        in_valid = 1'b0;
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step();
        chk("drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
